// File: rtl/pc_next_stage.sv
// ============================================================================
// Module   : pc_next_stage
// Brief    : MIPS program counter with next-PC selection, flush and redirect count
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_src,
    input  logic             jump,
    input  logic [31:0]      ex_pc_plus4,
    input  logic [31:0]      branch_imm,
    input  logic [25:0]      jump_index,
    input  logic             stall,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_req,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_branch_target;
    logic [31:0]      w_jump_target;
    logic             w_redirect;
    logic             r_fetch_req;
    logic             r_flush;
    logic [CNT_W-1:0] r_count;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = ex_pc_plus4 + (branch_imm << 2);
    assign w_jump_target   = {ex_pc_plus4[31:28], jump_index, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect wins over stall and any pending imem wait, and always lands in FETCH.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redirect  = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
            end
            FETCH, HOLD: begin
                if (jump) begin
                    w_pc_nxt    = w_jump_target;
                    w_redirect  = 1'b1;
                    w_state_nxt = FETCH;
                end else if (pc_src) begin
                    w_pc_nxt    = w_branch_target;
                    w_redirect  = 1'b1;
                    w_state_nxt = FETCH;
                end else if (stall) begin
                    w_state_nxt = HOLD;
                end else if (imem_ready) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_fetch_req <= 1'b0;
            r_flush     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_fetch_req <= (w_state_nxt != BOOT);
            r_flush     <= w_redirect;
            if (w_redirect && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign fetch_req      = r_fetch_req;
    assign flush          = r_flush;
    assign redirect_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_stage.sv
// ============================================================================
// Module   : tb_pc_next_stage
// Brief    : Directed self-checking bench for pc_next_stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_next_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic        jump;
    logic [31:0] ex_pc_plus4;
    logic [31:0] branch_imm;
    logic [25:0] jump_index;
    logic        stall;
    logic        imem_ready;

    logic [31:0] pc_a, pc_plus4_a;
    logic        fetch_req_a, flush_a;
    logic [15:0] cnt_a;

    logic [31:0] pc_b, pc_plus4_b;
    logic        fetch_req_b, flush_b;
    logic [15:0] cnt_b;

    logic [31:0] pc_c, pc_plus4_c;
    logic        fetch_req_c, flush_c;
    logic [1:0]  cnt_c;

    int total = 0;
    int bad   = 0;

    pc_next_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump),
        .ex_pc_plus4(ex_pc_plus4), .branch_imm(branch_imm), .jump_index(jump_index),
        .stall(stall), .imem_ready(imem_ready),
        .pc(pc_a), .pc_plus4(pc_plus4_a), .fetch_req(fetch_req_a),
        .flush(flush_a), .redirect_count(cnt_a)
    );

    pc_next_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump),
        .ex_pc_plus4(ex_pc_plus4), .branch_imm(branch_imm), .jump_index(jump_index),
        .stall(stall), .imem_ready(imem_ready),
        .pc(pc_b), .pc_plus4(pc_plus4_b), .fetch_req(fetch_req_b),
        .flush(flush_b), .redirect_count(cnt_b)
    );

    pc_next_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jump(jump),
        .ex_pc_plus4(ex_pc_plus4), .branch_imm(branch_imm), .jump_index(jump_index),
        .stall(stall), .imem_ready(imem_ready),
        .pc(pc_c), .pc_plus4(pc_plus4_c), .fetch_req(fetch_req_c),
        .flush(flush_c), .redirect_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pc_src = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        ex_pc_plus4 = 32'h0; branch_imm = 32'h0; jump_index = 26'h0;

        // Reset then free-running fetch
        tick(); tick();
        check("rst_pc", pc_a, 32'h0);
        check("rst_fetch_req", {31'h0, fetch_req_a}, 32'h0);
        check("rst_flush", {31'h0, flush_a}, 32'h0);
        check("rst_count", {16'h0, cnt_a}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("boot_fetch_req", {31'h0, fetch_req_a}, 32'h0);
        tick();
        check("run_pc0", pc_a, 32'h0);
        check("run_fetch_req", {31'h0, fetch_req_a}, 32'h1);
        tick(); check("run_pc4", pc_a, 32'h4);
        tick(); check("run_pc8", pc_a, 32'h8);
        tick(); check("run_pcC", pc_a, 32'hC);
        check("run_flush", {31'h0, flush_a}, 32'h0);
        check("run_pc_plus4", pc_plus4_a, 32'h10);

        // Taken branch with negative offset
        pc_src = 1'b1; ex_pc_plus4 = 32'h100; branch_imm = 32'hFFFF_FFFC;
        tick();
        check("br_pc", pc_a, 32'hF0);
        check("br_flush", {31'h0, flush_a}, 32'h1);
        check("br_count", {16'h0, cnt_a}, 32'h1);
        pc_src = 1'b0;
        tick();
        check("br_pc_after", pc_a, 32'hF4);
        check("br_flush_after", {31'h0, flush_a}, 32'h0);

        // Jump beats branch
        jump = 1'b1; pc_src = 1'b1; ex_pc_plus4 = 32'h4000_0010;
        jump_index = 26'h0000040; branch_imm = 32'h8;
        tick();
        check("jmp_pc", pc_a, 32'h4000_0100);
        check("jmp_flush", {31'h0, flush_a}, 32'h1);
        check("jmp_count", {16'h0, cnt_a}, 32'h2);
        jump = 1'b0; pc_src = 1'b0;
        tick();
        check("jmp_pc_after", pc_a, 32'h4000_0104);
        check("jmp_flush_after", {31'h0, flush_a}, 32'h0);

        // Back-to-back redirects keep flush high; jump to 0x20 sets up the stall case
        pc_src = 1'b1; ex_pc_plus4 = 32'h200; branch_imm = 32'h4;
        tick();
        check("b2b_pc1", pc_a, 32'h210);
        pc_src = 1'b0; jump = 1'b1; ex_pc_plus4 = 32'h0; jump_index = 26'h8;
        tick();
        check("b2b_pc2", pc_a, 32'h20);
        check("b2b_flush", {31'h0, flush_a}, 32'h1);
        check("b2b_count", {16'h0, cnt_a}, 32'h4);
        check("sat_count", {30'h0, cnt_c}, 32'h3);
        jump = 1'b0;

        // Stall with a branch arriving in the second stall cycle
        stall = 1'b1;
        tick();
        check("stall1_pc", pc_a, 32'h20);
        check("stall1_flush", {31'h0, flush_a}, 32'h0);
        check("stall1_fetch_req", {31'h0, fetch_req_a}, 32'h1);
        pc_src = 1'b1; ex_pc_plus4 = 32'h40; branch_imm = 32'h10;
        tick();
        check("stall2_pc", pc_a, 32'h80);
        check("stall2_flush", {31'h0, flush_a}, 32'h1);
        check("stall2_count", {16'h0, cnt_a}, 32'h5);
        check("sat_count_hold", {30'h0, cnt_c}, 32'h3);
        pc_src = 1'b0;
        tick();
        check("stall3_pc", pc_a, 32'h80);
        check("stall3_flush", {31'h0, flush_a}, 32'h0);
        stall = 1'b0;
        tick();
        check("unstall_pc", pc_a, 32'h84);

        // imem wait while not stalled holds pc
        imem_ready = 1'b0;
        tick();
        check("imem_wait_pc", pc_a, 32'h84);
        imem_ready = 1'b1;

        // Reset on the same edge as a taken branch
        rst_n = 1'b0; pc_src = 1'b1; ex_pc_plus4 = 32'h1000; branch_imm = 32'h0;
        tick();
        check("rstbr_pc", pc_a, 32'h0);
        check("rstbr_flush", {31'h0, flush_a}, 32'h0);
        check("rstbr_count", {16'h0, cnt_a}, 32'h0);
        check("rstbr_fetch_req", {31'h0, fetch_req_a}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("boot_ignores_br_pc", pc_a, 32'h0);
        check("boot_ignores_br_flush", {31'h0, flush_a}, 32'h0);
        check("boot_exit_fetch_req", {31'h0, fetch_req_a}, 32'h1);
        pc_src = 1'b0;

        // imem wait then wrap past the top of the address space
        rst_n = 1'b0; imem_ready = 1'b0;
        tick(); tick();
        check("wrap_rst_pc", pc_b, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        tick();
        check("wrap_boot_pc", pc_b, 32'hFFFF_FFF8);
        check("wrap_fetch_req", {31'h0, fetch_req_b}, 32'h1);
        tick();
        check("wrap_wait1_pc", pc_b, 32'hFFFF_FFF8);
        tick();
        check("wrap_wait2_pc", pc_b, 32'hFFFF_FFF8);
        imem_ready = 1'b1;
        tick();
        check("wrap_pcFFC", pc_b, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4_b, 32'h0);
        tick();
        check("wrap_pc0", pc_b, 32'h0);
        check("wrap_flush", {31'h0, flush_b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_next_stage.md
Name: pc_next_stage

Overview:
- Program-counter register and next-PC selector for the 32-bit MIPS datapath.
- Consumes the single-bit branch-taken decision `pc_src`, produced upstream by the Branch AND Zero gate.
- Also consumes the jump control, hazard stall and instruction-memory handshake, and drives the fetch address into IF.
- Generates a one-cycle pipeline flush on every redirect and keeps a saturating redirect counter for debug.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
CNT_W  16  width of redirect_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
pc_src  input  1  branch taken (Branch && Zero), sampled on clk
jump  input  1  unconditional jump resolved in EX
ex_pc_plus4  input  32  PC+4 of the instruction in EX (branch/jump owner)
branch_imm  input  32  sign-extended branch immediate (word offset)
jump_index  input  26  instr[25:0] of the jump in EX
stall  input  1  hazard unit freeze request
imem_ready  input  1  instruction memory accepted/returned current fetch
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4 (combinational from pc)
fetch_req  output  1  fetch address valid to instruction memory
flush  output  1  squash IF/ID contents, one cycle pulse
redirect_count  output  CNT_W  number of redirects since reset, saturating

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low, and takes priority over everything.
- Reset values: pc=RESET_PC, fetch_req=0, flush=0, redirect_count=0, state=BOOT.
- States:
  - BOOT: fetch_req=0 for exactly one cycle after reset deassert, then go to FETCH. pc_src and jump are ignored in BOOT.
  - FETCH: fetch_req=1.
    - imem_ready=1 and no stall/redirect: pc<=pc+4 next cycle; stay in FETCH.
    - imem_ready=0: hold pc.
  - HOLD: entered when stall=1 in FETCH. fetch_req=1, pc held. Return to FETCH the cycle after stall drops.
- Targets:
  - branch_target = ex_pc_plus4 + (branch_imm << 2), modulo 2^32.
  - jump_target = {ex_pc_plus4[31:28], jump_index, 2'b00}.
- Next-PC priority, per cycle, in FETCH or HOLD:
  1. jump=1: pc <= jump_target.
  2. else pc_src=1: pc <= branch_target.
  3. else stall=1: hold.
  4. else imem_ready=1: pc+4.
  5. else hold.
- Redirect rules:
  - A redirect overrides stall and any outstanding imem_ready wait; the abandoned fetch is discarded.
  - The redirect lands in FETCH.
  - flush=1 in the cycle after the redirect edge, i.e. registered and coincident with the new pc. Otherwise flush=0.
  - Back-to-back redirects each produce a flush pulse; flush stays high across consecutive cycles.
- redirect_count increments by 1 per redirect and saturates at 2^CNT_W-1.
- Arithmetic:
  - pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
  - pc[1:0] is always 2'b00 (RESET_PC must be word-aligned).
  - Only pc_plus4 is combinational; all other outputs are registered.
- Reset mid-operation: a synchronous rst_n=0 in any state restores the reset values on the next edge, including mid-stall and mid-redirect. A pending flush is cancelled.

Test Plan:
1. Reset then run: rst_n low 2 cycles, release, imem_ready=1 constant -> fetch_req=0 for 1 cycle; pc then 0x0, 0x4, 0x8, 0xC on successive cycles; flush=0.
2. Taken branch: pc_src=1 one cycle, ex_pc_plus4=0x100, branch_imm=32'hFFFF_FFFC -> next pc=0xF0; flush=1 for exactly that cycle; redirect_count=1.
3. Jump beats branch: jump=1 and pc_src=1 same cycle, ex_pc_plus4=0x4000_0010, jump_index=26'h0000040, branch_imm=8 -> pc=0x4000_0100; single flush; count +1.
4. Stall vs redirect: stall=1 for 3 cycles holds pc=0x20; pc_src=1 (target 0x80) asserted in the 2nd stall cycle -> pc=0x80 next cycle despite stall; flush pulse.
5. imem wait and wrap: RESET_PC=32'hFFFF_FFF8, imem_ready low 2 cycles then high -> pc holds 0xFFFF_FFF8, then 0xFFFF_FFFC, then 0x0000_0000.
6. Reset mid-redirect: rst_n=0 on the same edge as pc_src=1 -> pc=RESET_PC, flush=0, redirect_count=0, BOOT cycle with fetch_req=0.
